charlie_scan_ctrl: RTL and testbench
====================================

CHARLIE_SCAN_CTRL -- requirements
Module: charlie_scan_ctrl

Interface
REQ-001 The block SHALL have the parameter NUM_DIGITS, default 8: the number of digits scanned.
REQ-002 The block SHALL have the parameter NUM_SEGMENTS, default 7: the number of segment slots per digit.
REQ-003 The block SHALL have the parameter BLANK_CYCLES, default 2: the dead-time cycles at the start of every slot (anti-ghosting).
REQ-004 The block SHALL have the parameter ON_UNIT, default 2: the on-time cycles per brightness step; SLOT_CYCLES = BLANK_CYCLES + 15*ON_UNIT (default 32).
REQ-005 The block SHALL have the port clk, input, width 1: the single clock; all state is on its rising edge.
REQ-006 The block SHALL have the port rst, input, width 1: reset, asynchronous and active-high.
REQ-007 The block SHALL have the port enable, input, width 1: 1 runs the scan, 0 idles the display.
REQ-008 The block SHALL have the port brightness, input, width 4: the on-time in ON_UNIT steps (0 = dark, 15 = max).
REQ-009 The block SHALL have the port frame_data, input, width 32: eight hex nibbles, with digit k at bits [4k+3:4k].
REQ-010 The block SHALL have the port frame_valid, input, width 1: a new frame is offered.
REQ-011 The block SHALL have the port frame_ready, output, width 1: the shadow buffer is free.
REQ-012 The block SHALL have the port digit, output, width 3: the active digit index, driven high by the pin stage.
REQ-013 The block SHALL have the port segment, output, width 3: the active segment index, 0..NUM_SEGMENTS-1.
REQ-014 The block SHALL have the port drive_en, output, width 1: 1 permits the pin stage to light the selected segment.
REQ-015 The block SHALL have the port shown_data, output, width 32: the frame currently being scanned.
REQ-016 The block SHALL have the port frame_start, output, width 1: a one-cycle pulse on the first cycle of slot (digit 0, segment 0).

Function
REQ-017 All outputs SHALL be registered; digit, segment, drive_en and frame_start SHALL change on the same edge.
REQ-018 The FSM SHALL have the states IDLE, BLANK and ON.
- IDLE -> BLANK when enable=1.
- BLANK -> ON after BLANK_CYCLES cycles.
- ON -> BLANK at slot end.
- Any state -> IDLE when enable=0, on the next edge.
REQ-019 The slot counter SHALL run 0..SLOT_CYCLES-1 and wrap; BLANK covers counts 0..BLANK_CYCLES-1.
REQ-020 drive_en SHALL be 1 for exactly b*ON_UNIT cycles starting at count BLANK_CYCLES, where b is brightness latched at count 0 of each slot.
REQ-021 drive_en SHALL be 0 in the remaining counts of ON, in BLANK, and in IDLE.
REQ-022 At slot wrap, segment SHALL increment; at NUM_SEGMENTS-1 it SHALL wrap to 0 and digit SHALL increment; at NUM_DIGITS-1 digit SHALL wrap to 0 (frame boundary).
REQ-023 In IDLE, digit, segment and the slot counter SHALL be held at 0.
REQ-024 When enable rises at edge N, the first cycle of slot (0,0) with frame_start=1 SHALL appear at cycle N+1.
REQ-025 frame_start SHALL pulse once per frame, and only in a cycle where digit=0, segment=0 and count=0.
REQ-026 frame_ready SHALL equal the inverse of the pending flag; a handshake occurs on frame_valid & frame_ready.
REQ-027 On a handshake, frame_data SHALL be written to the shadow buffer and pending set to 1.
REQ-028 At the frame boundary edge, or on any edge while in IDLE, a pending shadow SHALL be copied to shown_data and pending cleared.
REQ-029 When a handshake coincides with the boundary edge, or occurs in IDLE, frame_data SHALL be written directly to shown_data and pending SHALL stay 0.
REQ-030 shown_data SHALL never change mid-frame while the scan runs.
REQ-031 frame_valid while pending=1 SHALL be ignored, and the shadow buffer SHALL be left unchanged.
REQ-032 A brightness change mid-slot SHALL take effect only at the next slot start.

Reset
REQ-033 While rst=1, the outputs SHALL be: state IDLE, digit=0, segment=0, count=0, drive_en=0, frame_start=0, shown_data=0, pending=0, frame_ready=0.
REQ-034 frame_ready SHALL rise on the first clk edge after rst deasserts.
REQ-035 rst asserted mid-slot SHALL force drive_en=0 immediately (asynchronous) and SHALL discard a pending shadow.

Verification
REQ-036 Reset, enable=1, brightness=15, defaults -> frame_start every 1792 cycles; each slot has 2 cycles drive_en=0 then 30 cycles drive_en=1; segment/digit sequence is (0,0),(0,1)..(0,6),(1,0)..(7,6).
REQ-037 brightness=1 -> drive_en=1 for exactly 2 cycles per slot, at counts 2-3; brightness=0 -> drive_en=0 throughout.
REQ-038 Send 0x12345678 mid-frame -> frame_ready drops and shown_data changes to 0x12345678 only on the edge where frame_start next rises; then send 0xDEADBEEF while pending -> ignored until ready.
REQ-039 Handshake on the boundary edge -> shown_data updates that edge; frame_ready stays 1.
REQ-040 enable=0 mid-slot -> next cycle drive_en=0 and digit=segment=0; a frame sent while idle appears on shown_data after 1 cycle; enable=1 -> frame_start after 1 cycle.
REQ-041 rst pulse mid-ON with a pending frame -> drive_en=0 without a clock edge; after release shown_data=0 and frame_ready=1.

Source files
------------

// File: rtl/charlie_scan_ctrl.sv
// Charlieplexed display scan controller.
// Steps through every (digit, segment) slot in turn. Each slot starts with a
// dead-time blank, then lights the segment for a brightness-scaled on-time.
// New frames go into a shadow buffer. The shadow is promoted to the displayed
// frame only on a frame boundary, so a frame never tears mid-scan.
module charlie_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int NUM_SEGMENTS = 7,
  parameter int BLANK_CYCLES = 2,
  parameter int ON_UNIT      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  brightness,
  input  logic [31:0] frame_data,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic [2:0]  digit,
  output logic [2:0]  segment,
  output logic        drive_en,
  output logic [31:0] shown_data,
  output logic        frame_start
);

  localparam int SLOT_CYCLES = BLANK_CYCLES + 15 * ON_UNIT;
  localparam int CW          = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  localparam logic [CW-1:0] LAST_SLOT  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] LAST_BLANK = CW'(BLANK_CYCLES - 1);
  localparam logic [2:0]    LAST_DIG   = 3'(NUM_DIGITS - 1);
  localparam logic [2:0]    LAST_SEG   = 3'(NUM_SEGMENTS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [3:0]    bright_reg, bright_next;
  logic [2:0]    digit_next, segment_next;
  logic          drive_next, start_next;
  logic [3:0]    bright_eff;
  logic          slot_end, frame_end, boundary, handshake;
  logic [31:0]   shadow_reg;
  logic          pending_reg;

  assign slot_end  = (count_reg == LAST_SLOT);
  assign frame_end = slot_end && (digit == LAST_DIG) && (segment == LAST_SEG);
  // IDLE edges count as boundaries too, so a frame offered while idle shows at once.
  assign boundary  = (state_reg == IDLE) || (enable && frame_end);
  assign handshake = frame_valid && frame_ready;
  // On the count-0 edge the latch is only just being loaded, so take the live input.
  assign bright_eff = (count_reg == '0) ? brightness : bright_reg;

  // Next-state, slot/segment/digit sequencing and registered-output precompute
  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    bright_next  = bright_reg;
    digit_next   = digit;
    segment_next = segment;
    start_next   = 1'b0;
    drive_next   = 1'b0;

    if (!enable) begin
      state_next   = IDLE;
      count_next   = '0;
      digit_next   = '0;
      segment_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next   = BLANK;
          count_next   = '0;
          digit_next   = '0;
          segment_next = '0;
          start_next   = 1'b1;
        end
        default: begin
          if (count_reg == '0) bright_next = brightness;
          if (slot_end) begin
            state_next = BLANK;
            count_next = '0;
            start_next = frame_end;
            if (segment == LAST_SEG) begin
              segment_next = '0;
              digit_next   = (digit == LAST_DIG) ? 3'd0 : digit + 3'd1;
            end else begin
              segment_next = segment + 3'd1;
            end
          end else begin
            count_next = count_reg + CW'(1);
            if (state_reg == BLANK && count_reg == LAST_BLANK) state_next = ON;
          end
        end
      endcase
    end

    drive_next = (state_next == ON) &&
                 (int'(count_next) < BLANK_CYCLES + int'(bright_eff) * ON_UNIT);
  end

  // Scan state and pin-facing outputs, all updated on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      bright_reg  <= '0;
      digit       <= '0;
      segment     <= '0;
      drive_en    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      bright_reg  <= bright_next;
      digit       <= digit_next;
      segment     <= segment_next;
      drive_en    <= drive_next;
      frame_start <= start_next;
    end
  end

  // Frame double-buffering: the shadow takes a frame mid-scan, and shown_data changes only at a boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shown_data  <= '0;
      shadow_reg  <= '0;
      pending_reg <= 1'b0;
      frame_ready <= 1'b0;
    end else if (boundary) begin
      if (handshake)        shown_data <= frame_data;
      else if (pending_reg) shown_data <= shadow_reg;
      pending_reg <= 1'b0;
      frame_ready <= 1'b1;
    end else if (handshake) begin
      shadow_reg  <= frame_data;
      pending_reg <= 1'b1;
      frame_ready <= 1'b0;
    end else begin
      frame_ready <= ~pending_reg;
    end
  end

endmodule

// File: tb/tb_charlie_scan_ctrl.sv
// Bench for charlie_scan_ctrl. The reference model treats the scan as one
// running cycle position inside a 1792-cycle frame. Count, segment and digit
// follow from division and modulo of that position, and drive_en follows from
// the slot offset and the brightness seen at the slot start.
module tb_charlie_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  brightness = 4'd0;
  logic [31:0] frame_data = 32'd0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic [2:0]  digit;
  logic [2:0]  segment;
  logic        drive_en;
  logic [31:0] shown_data;
  logic        frame_start;

  charlie_scan_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable), .brightness(brightness),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .digit(digit), .segment(segment), .drive_en(drive_en),
    .shown_data(shown_data), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  localparam int SLOT  = 32;
  localparam int FRAME = 8 * 7 * SLOT;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          m_run;
  int          m_pos;
  int          m_b;
  logic [31:0] m_shown, m_shadow;
  bit          m_pend, m_ready;

  typedef struct {
    bit          en;
    logic [3:0]  bri;
    bit          fv;
    logic [31:0] fd;
    bit          x_drive;
    logic [2:0]  x_digit;
    logic [2:0]  x_seg;
    bit          x_fs;
    logic [31:0] x_shown;
    bit          x_ready;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_b = 0;
    m_shown = '0; m_shadow = '0; m_pend = 0; m_ready = 0;
  endtask

  // Apply one clock edge to the model using the inputs as they were sampled on that edge.
  task automatic model_edge();
    bit hs, bnd;
    hs  = frame_valid && m_ready;
    bnd = !m_run || (enable && (m_pos % FRAME == FRAME - 1));
    if (m_run && (m_pos % SLOT == 0)) m_b = int'(brightness);
    if (!enable)     begin m_run = 0; m_pos = 0; end
    else if (!m_run) begin m_run = 1; m_pos = 0; end
    else             m_pos = (m_pos + 1) % FRAME;
    if (bnd) begin
      if (hs) m_shown = frame_data;
      else if (m_pend) m_shown = m_shadow;
      m_pend = 0;
    end else if (hs) begin
      m_shadow = frame_data;
      m_pend = 1;
    end
    m_ready = !m_pend;
  endtask

  task automatic check_all();
    int c;
    c = m_pos % SLOT;
    check("digit",       digit,       32'(m_pos / (7 * SLOT)));
    check("segment",     segment,     32'((m_pos / SLOT) % 7));
    check("drive_en",    drive_en,    32'(m_run && c >= 2 && c < 2 + 2 * m_b));
    check("frame_start", frame_start, 32'(m_run && m_pos == 0));
    check("shown_data",  shown_data,  m_shown);
    check("frame_ready", frame_ready, 32'(m_ready));
  endtask

  // One cycle: drive the inputs after negedge, let the edge happen, then compare at the next negedge.
  task automatic step(input bit en, input logic [3:0] bri, input bit fv, input logic [31:0] fd);
    enable = en; brightness = bri; frame_valid = fv; frame_data = fd;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int fs_cnt, last_fs, drv_cnt, guard;
    logic [31:0] old_shown;

    tbl[0] = '{0, 4'd0,  0, 32'h0,         0, 3'd0, 3'd0, 0, 32'h0,         1};
    tbl[1] = '{0, 4'd0,  1, 32'hA5A5_0F0F, 0, 3'd0, 3'd0, 0, 32'hA5A5_0F0F, 1};
    tbl[2] = '{1, 4'd1,  0, 32'h0,         0, 3'd0, 3'd0, 1, 32'hA5A5_0F0F, 1};
    tbl[3] = '{1, 4'd1,  0, 32'h0,         0, 3'd0, 3'd0, 0, 32'hA5A5_0F0F, 1};
    tbl[4] = '{1, 4'd15, 0, 32'h0,         1, 3'd0, 3'd0, 0, 32'hA5A5_0F0F, 1};
    tbl[5] = '{1, 4'd15, 0, 32'h0,         1, 3'd0, 3'd0, 0, 32'hA5A5_0F0F, 1};
    tbl[6] = '{1, 4'd15, 0, 32'h0,         0, 3'd0, 3'd0, 0, 32'hA5A5_0F0F, 1};
    tbl[7] = '{0, 4'd15, 0, 32'h0,         0, 3'd0, 3'd0, 0, 32'hA5A5_0F0F, 1};

    // reset state
    model_reset();
    @(negedge clk); @(negedge clk);
    check("rst_digit",   digit,       32'd0);
    check("rst_segment", segment,     32'd0);
    check("rst_drive",   drive_en,    32'd0);
    check("rst_fs",      frame_start, 32'd0);
    check("rst_shown",   shown_data,  32'd0);
    check("rst_ready",   frame_ready, 32'd0);
    rst = 1'b0;

    // table vectors: idle handshake, start latency, brightness-1 window, mid-slot brightness change
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].en, tbl[i].bri, tbl[i].fv, tbl[i].fd);
      check($sformatf("tbl%0d_drive", i),   drive_en,    32'(tbl[i].x_drive));
      check($sformatf("tbl%0d_digit", i),   digit,       32'(tbl[i].x_digit));
      check($sformatf("tbl%0d_segment", i), segment,     32'(tbl[i].x_seg));
      check($sformatf("tbl%0d_fs", i),      frame_start, 32'(tbl[i].x_fs));
      check($sformatf("tbl%0d_shown", i),   shown_data,  tbl[i].x_shown);
      check($sformatf("tbl%0d_ready", i),   frame_ready, 32'(tbl[i].x_ready));
    end

    // full frame at brightness 15: 30 lit cycles in each of 56 slots, frame period 1792
    fs_cnt = 0; last_fs = -1; drv_cnt = 0;
    for (int k = 0; k <= FRAME; k++) begin
      step(1, 4'd15, 0, 32'h0);
      if (frame_start) begin fs_cnt++; last_fs = k; end
      if (k < FRAME && drive_en) drv_cnt++;
    end
    check("frame_fs_count",  32'(fs_cnt),  32'd2);
    check("frame_period",    32'(last_fs), 32'(FRAME));
    check("frame_drive_sum", 32'(drv_cnt), 32'(56 * 30));

    // brightness 0 over a full slot keeps drive_en low
    for (int k = 0; k < 2 * SLOT; k++) step(1, 4'd0, 0, 32'h0);

    // mid-frame handshake, then a second offer while pending is ignored
    for (int k = 0; k < 40; k++) step(1, 4'd7, 0, 32'h0);
    old_shown = shown_data;
    step(1, 4'd7, 1, 32'h1234_5678);
    check("pend_ready_low", frame_ready, 32'd0);
    check("pend_shown_old", shown_data,  old_shown);
    step(1, 4'd7, 1, 32'hDEAD_BEEF);
    check("ignored_ready", frame_ready, 32'd0);
    guard = 0;
    while (!frame_start && guard < FRAME + 10) begin
      check("no_tear", shown_data, (m_pos == 0) ? 32'h1234_5678 : old_shown);
      step(1, 4'd7, 0, 32'h0);
      guard++;
    end
    check("boundary_reached", 32'(frame_start), 32'd1);
    check("promoted_shown",   shown_data,  32'h1234_5678);
    check("promoted_ready",   frame_ready, 32'd1);

    // handshake exactly on the boundary edge goes straight to shown_data
    guard = 0;
    while (m_pos != FRAME - 1 && guard < FRAME + 10) begin
      step(1, 4'd3, 0, 32'h0);
      guard++;
    end
    check("edge_pos_reached", 32'(m_pos), 32'(FRAME - 1));
    step(1, 4'd3, 1, 32'hCAFE_F00D);
    check("edge_shown", shown_data,  32'hCAFE_F00D);
    check("edge_ready", frame_ready, 32'd1);
    check("edge_fs",    frame_start, 32'd1);

    // disable mid-slot, load while idle, re-enable
    for (int k = 0; k < 45; k++) step(1, 4'd9, 0, 32'h0);
    step(0, 4'd9, 0, 32'h0);
    check("idle_drive",   drive_en, 32'd0);
    check("idle_digit",   digit,    32'd0);
    check("idle_segment", segment,  32'd0);
    step(0, 4'd9, 1, 32'h0BAD_C0DE);
    check("idle_load", shown_data, 32'h0BAD_C0DE);
    step(1, 4'd9, 0, 32'h0);
    check("restart_fs", frame_start, 32'd1);

    // asynchronous reset in the lit part of a slot while a frame is pending
    for (int k = 0; k < 40; k++) step(1, 4'd15, 0, 32'h0);
    step(1, 4'd15, 1, 32'h5555_AAAA);
    for (int k = 0; k < 3; k++) step(1, 4'd15, 0, 32'h0);
    check("pre_rst_drive", drive_en,    32'd1);
    check("pre_rst_pend",  frame_ready, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async_drive", drive_en,   32'd0);
    check("async_shown", shown_data, 32'd0);
    model_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    step(0, 4'd0, 0, 32'h0);
    check("post_rst_shown", shown_data,  32'd0);
    check("post_rst_ready", frame_ready, 32'd1);

    // randomized traffic against the model
    for (int k = 0; k < 4000; k++) begin
      step($urandom_range(0, 299) != 0, 4'($urandom_range(0, 15)),
           $urandom_range(0, 3) == 0, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
